// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream gap shaper.
// Gate states and mode encodings used by the top and the bench.
package axis_pkg;

   typedef enum logic [0:0] {
      PASS = 1'b0,
      HALT = 1'b1
   } gap_state_t;

   localparam logic GAP_MODE    = 1'b0;
   localparam logic PERIOD_MODE = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with a registered upstream ready.
// Sustains one beat per cycle; the skid entry absorbs the ready lag.
module axis_skid_buffer #(
   parameter int AXIS_BYTES = 1
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    s_tlast,
   input  logic [AXIS_BYTES-1:0]   s_tkeep,
   input  logic [AXIS_BYTES*8-1:0] s_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic [AXIS_BYTES-1:0]   m_tkeep,
   output logic [AXIS_BYTES*8-1:0] m_tdata
);

   localparam int W = AXIS_BYTES * 9 + 1;

   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         main_vld, main_vld_d;
   logic         skid_vld, skid_vld_d;
   logic         rdy_q;
   logic         push, pop;

   assign push     = s_tvalid & rdy_q;
   assign pop      = main_vld & m_tready;
   assign s_tready = rdy_q;
   assign m_tvalid = main_vld;
   assign {m_tlast, m_tkeep, m_tdata} = main_q;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld;
      skid_vld_d = skid_vld;
      if (pop) begin
         main_d     = skid_q;
         main_vld_d = skid_vld;
         skid_vld_d = 1'b0;
      end
      if (push) begin
         if (!main_vld_d) begin
            main_d     = {s_tlast, s_tkeep, s_tdata};
            main_vld_d = 1'b1;
         end else begin
            skid_d     = {s_tlast, s_tkeep, s_tdata};
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_vld <= main_vld_d;
         skid_vld <= skid_vld_d;
         rdy_q    <= ~skid_vld_d;
      end
   end

endmodule

// File: rtl/axis_gap_shaper.sv
// AXI-Stream packet spacer: idle-gap or start-to-start period gating.
// Beats inside a packet are never stalled; only packet starts are held.
module axis_gap_shaper
   import axis_pkg::*;
#(
   parameter int AXIS_BYTES     = 1,
   parameter int GAP_WIDTH      = 8,
   parameter int REGISTER_INPUT = 1,
   parameter int PKT_CTR_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic [GAP_WIDTH-1:0]     cfg_gap,
   input  logic                     cfg_mode,
   output logic                     axis_i_tready,
   input  logic                     axis_i_tvalid,
   input  logic                     axis_i_tlast,
   input  logic [AXIS_BYTES-1:0]    axis_i_tkeep,
   input  logic [AXIS_BYTES*8-1:0]  axis_i_tdata,
   input  logic                     axis_o_tready,
   output logic                     axis_o_tvalid,
   output logic                     axis_o_tlast,
   output logic [AXIS_BYTES-1:0]    axis_o_tkeep,
   output logic [AXIS_BYTES*8-1:0]  axis_o_tdata,
   output logic                     status_halted,
   output logic [PKT_CTR_WIDTH-1:0] status_pkt_count
);

   localparam logic [GAP_WIDTH-1:0] CTR_ONE = GAP_WIDTH'(1);

   logic                    b_valid;
   logic                    b_ready;
   logic                    b_last;
   logic [AXIS_BYTES-1:0]   b_keep;
   logic [AXIS_BYTES*8-1:0] b_data;

   generate
      if (REGISTER_INPUT != 0) begin : g_skid
         axis_skid_buffer #(
            .AXIS_BYTES (AXIS_BYTES)
         ) u_skid (
            .clk      (clk),
            .aresetn  (aresetn),
            .s_tvalid (axis_i_tvalid),
            .s_tready (axis_i_tready),
            .s_tlast  (axis_i_tlast),
            .s_tkeep  (axis_i_tkeep),
            .s_tdata  (axis_i_tdata),
            .m_tvalid (b_valid),
            .m_tready (b_ready),
            .m_tlast  (b_last),
            .m_tkeep  (b_keep),
            .m_tdata  (b_data)
         );
      end else begin : g_pass
         // Reset gating keeps the combinational path quiet while held.
         assign b_valid       = axis_i_tvalid & aresetn;
         assign axis_i_tready = b_ready & aresetn;
         assign b_last        = axis_i_tlast;
         assign b_keep        = axis_i_tkeep;
         assign b_data        = axis_i_tdata;
      end
   endgenerate

   gap_state_t           state;
   logic [GAP_WIDTH-1:0] ctr;
   logic                 in_pkt;
   logic                 open;
   logic                 xfer;
   logic                 start;
   logic                 last_x;

   assign open   = in_pkt | (state == PASS);
   assign xfer   = axis_o_tvalid & axis_o_tready;
   assign start  = xfer & ~in_pkt;
   assign last_x = xfer & b_last;

   assign axis_o_tvalid = b_valid & open;
   assign b_ready       = axis_o_tready & open;
   assign axis_o_tlast  = b_last;
   assign axis_o_tkeep  = b_keep;
   assign axis_o_tdata  = b_data;
   assign status_halted = (state == HALT) & ~in_pkt;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state            <= PASS;
         ctr              <= '0;
         in_pkt           <= 1'b0;
         status_pkt_count <= '0;
      end else begin
         if (xfer) in_pkt <= ~b_last;
         if (last_x) status_pkt_count <= status_pkt_count + 1'b1;
         // Load events sample cfg; otherwise a running count just drains.
         if (cfg_mode == PERIOD_MODE && start && cfg_gap > CTR_ONE) begin
            ctr   <= cfg_gap - CTR_ONE;
            state <= HALT;
         end else if (cfg_mode == GAP_MODE && last_x && cfg_gap != '0) begin
            ctr   <= cfg_gap;
            state <= HALT;
         end else if (state == HALT) begin
            ctr <= ctr - CTR_ONE;
            if (ctr <= CTR_ONE) state <= PASS;
         end
      end
   end

endmodule

// File: tb/tb_axis_gap_shaper.sv
// Scoreboard bench for axis_gap_shaper: timing on a pass-through
// instance, ordering and gap spacing on a registered-input instance.
module tb_axis_gap_shaper;
   import axis_pkg::*;

   typedef struct packed {
      logic       last;
      logic [0:0] keep;
      logic [7:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  cfg_gap0, cfg_gap1;
   logic        cfg_mode0, cfg_mode1;
   logic        i_valid0, i_ready0, i_last0;
   logic [0:0]  i_keep0;
   logic [7:0]  i_data0;
   logic        o_valid0, o_rdy0, o_last0;
   logic [0:0]  o_keep0;
   logic [7:0]  o_data0;
   logic        halted0;
   logic [15:0] pkt0;
   logic        i_valid1, i_ready1, i_last1;
   logic [0:0]  i_keep1;
   logic [7:0]  i_data1;
   logic        o_valid1, o_rdy1, o_last1;
   logic [0:0]  o_keep1;
   logic [7:0]  o_data1;
   logic        halted1;
   logic [15:0] pkt1;

   axis_gap_shaper #(
      .AXIS_BYTES(1), .GAP_WIDTH(8),
      .REGISTER_INPUT(0), .PKT_CTR_WIDTH(16)
   ) dut0 (
      .clk(clk), .aresetn(aresetn),
      .cfg_gap(cfg_gap0), .cfg_mode(cfg_mode0),
      .axis_i_tready(i_ready0), .axis_i_tvalid(i_valid0),
      .axis_i_tlast(i_last0), .axis_i_tkeep(i_keep0),
      .axis_i_tdata(i_data0), .axis_o_tready(o_rdy0),
      .axis_o_tvalid(o_valid0), .axis_o_tlast(o_last0),
      .axis_o_tkeep(o_keep0), .axis_o_tdata(o_data0),
      .status_halted(halted0), .status_pkt_count(pkt0)
   );

   axis_gap_shaper #(
      .AXIS_BYTES(1), .GAP_WIDTH(8),
      .REGISTER_INPUT(1), .PKT_CTR_WIDTH(16)
   ) dut1 (
      .clk(clk), .aresetn(aresetn),
      .cfg_gap(cfg_gap1), .cfg_mode(cfg_mode1),
      .axis_i_tready(i_ready1), .axis_i_tvalid(i_valid1),
      .axis_i_tlast(i_last1), .axis_i_tkeep(i_keep1),
      .axis_i_tdata(i_data1), .axis_o_tready(o_rdy1),
      .axis_o_tvalid(o_valid1), .axis_o_tlast(o_last1),
      .axis_o_tkeep(o_keep1), .axis_o_tdata(o_data1),
      .status_halted(halted1), .status_pkt_count(pkt1)
   );

   beat_t src0[$], sb0[$], src1[$], sb1[$];
   int    exc[$];
   logic  hh[0:63];
   int    vec = 0;
   int    bad = 0;
   int    chg_cyc = -1;
   logic [7:0] chg_val = 8'd0;
   int    st_lo = -1;
   int    st_hi = -1;

   task automatic push_pkt(input int len, input int tag, input bit to1);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = 8'(tag * 16 + i);
         b.keep = 1'($urandom_range(1));
         b.last = (i == len - 1);
         if (to1) src1.push_back(b);
         else src0.push_back(b);
      end
   endtask

   task automatic do_reset;
      aresetn = 1'b0;
      i_valid0 = 1'b0; i_last0 = 1'b0; i_keep0 = '0; i_data0 = '0;
      i_valid1 = 1'b0; i_last1 = 1'b0; i_keep1 = '0; i_data1 = '0;
      o_rdy0 = 1'b1; o_rdy1 = 1'b0;
      src0.delete(); sb0.delete(); src1.delete(); sb1.delete();
      exc.delete();
      chg_cyc = -1; st_lo = -1; st_hi = -1;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
   endtask

   // Drives dut0 from src0, checks beats and transfer cycles.
   task automatic run0(input string nm, input int ncyc);
      beat_t e;
      int    w;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (c == chg_cyc) cfg_gap0 = chg_val;
         o_rdy0 = !(c >= st_lo && c <= st_hi);
         i_valid0 = (src0.size() > 0);
         if (i_valid0) {i_last0, i_keep0, i_data0} = src0[0];
         #1;
         hh[c] = halted0;
         if (i_valid0 && i_ready0) sb0.push_back(src0.pop_front());
         if (o_valid0 && o_rdy0) begin
            vec++;
            if (sb0.size() == 0) begin
               bad++;
               $display("FAIL %s beat: unexpected output at cycle %0d", nm, c);
            end else begin
               e = sb0.pop_front();
               if ({o_last0, o_keep0, o_data0} !== e) begin
                  bad++;
                  $display("FAIL %s beat: got %h want %h", nm,
                           {o_last0, o_keep0, o_data0}, e);
               end
            end
            vec++;
            w = (exc.size() > 0) ? exc.pop_front() : -1;
            if (c != w) begin
               bad++;
               $display("FAIL %s cycle: transfer at %0d want %0d", nm, c, w);
            end
         end
      end
      @(negedge clk);
      i_valid0 = 1'b0;
      o_rdy0 = 1'b1;
      vec++;
      if (exc.size() != 0) begin
         bad++;
         $display("FAIL %s missing: %0d transfers, want 0", nm, exc.size());
      end
   endtask

   task automatic test_reset;
      aresetn = 1'b0;
      i_valid0 = 1'b1; i_valid1 = 1'b1;
      o_rdy0 = 1'b1; o_rdy1 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vec++;
      if ({o_valid0, i_ready0, halted0} !== 3'b000) begin
         bad++;
         $display("FAIL reset0: vld/rdy/halt %b want 000",
                  {o_valid0, i_ready0, halted0});
      end
      vec++;
      if ({o_valid1, i_ready1, halted1} !== 3'b000) begin
         bad++;
         $display("FAIL reset1: vld/rdy/halt %b want 000",
                  {o_valid1, i_ready1, halted1});
      end
      vec++;
      if (pkt0 !== 16'd0 || pkt1 !== 16'd0) begin
         bad++;
         $display("FAIL reset_cnt: %0d/%0d want 0", pkt0, pkt1);
      end
   endtask

   task automatic test_gap3;
      do_reset;
      cfg_mode0 = GAP_MODE; cfg_gap0 = 8'd3;
      push_pkt(4, 1, 0); push_pkt(4, 2, 0);
      exc = '{0, 1, 2, 3, 7, 8, 9, 10};
      run0("gap3", 14);
      vec++;
      if ({hh[4], hh[6], hh[7]} !== 3'b110) begin
         bad++;
         $display("FAIL gap3_halted: %b want 110", {hh[4], hh[6], hh[7]});
      end
      vec++;
      if (pkt0 !== 16'd2) begin
         bad++;
         $display("FAIL gap3_cnt: %0d want 2", pkt0);
      end
   endtask

   task automatic test_back_to_back;
      int nh = 0;
      do_reset;
      cfg_mode0 = GAP_MODE; cfg_gap0 = 8'd0;
      for (int p = 0; p < 10; p++) begin
         push_pkt(1, p, 0);
         exc.push_back(p);
      end
      run0("gap0", 12);
      for (int c = 0; c < 12; c++) nh += int'(hh[c]);
      vec++;
      if (nh != 0) begin
         bad++;
         $display("FAIL gap0_halted: %0d halted cycles want 0", nh);
      end
      vec++;
      if (pkt0 !== 16'd10) begin
         bad++;
         $display("FAIL gap0_cnt: %0d want 10", pkt0);
      end
   endtask

   task automatic test_period;
      do_reset;
      cfg_mode0 = PERIOD_MODE; cfg_gap0 = 8'd5;
      for (int p = 0; p < 3; p++) push_pkt(2, p, 0);
      exc = '{0, 1, 5, 6, 10, 11};
      run0("period5", 14);
      vec++;
      if (pkt0 !== 16'd3) begin
         bad++;
         $display("FAIL period5_cnt: %0d want 3", pkt0);
      end
      do_reset;
      cfg_mode0 = PERIOD_MODE; cfg_gap0 = 8'd2;
      push_pkt(6, 4, 0); push_pkt(6, 5, 0);
      for (int c = 0; c < 12; c++) exc.push_back(c);
      run0("period2", 14);
   endtask

   task automatic test_cfg_change;
      do_reset;
      cfg_mode0 = GAP_MODE; cfg_gap0 = 8'd4;
      push_pkt(2, 1, 0); push_pkt(2, 2, 0); push_pkt(2, 3, 0);
      chg_cyc = 3; chg_val = 8'd1;
      st_lo = 3; st_hi = 4;
      exc = '{0, 1, 6, 7, 9, 10};
      run0("cfgchg", 14);
      vec++;
      if ({hh[2], hh[5], hh[8]} !== 3'b111) begin
         bad++;
         $display("FAIL cfgchg_halted: %b want 111", {hh[2], hh[5], hh[8]});
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      cfg_mode0 = GAP_MODE; cfg_gap0 = 8'd3;
      push_pkt(4, 1, 0);
      exc = '{0, 1};
      run0("rst_pkt", 2);
      aresetn = 1'b0;
      i_valid0 = 1'b1;
      #1;
      vec++;
      if ({o_valid0, halted0, i_ready0} !== 3'b000) begin
         bad++;
         $display("FAIL rst_pkt_out: vld/halt/rdy %b want 000",
                  {o_valid0, halted0, i_ready0});
      end
      i_valid0 = 1'b0;
      src0.delete(); sb0.delete();
      @(negedge clk);
      aresetn = 1'b1;
      push_pkt(1, 7, 0);
      exc = '{0};
      run0("rst_pkt_after", 3);
      vec++;
      if (pkt0 !== 16'd1) begin
         bad++;
         $display("FAIL rst_pkt_cnt: %0d want 1", pkt0);
      end
      do_reset;
      cfg_mode0 = GAP_MODE; cfg_gap0 = 8'd5;
      push_pkt(1, 8, 0); push_pkt(1, 9, 0);
      exc = '{0};
      run0("rst_halt", 3);
      vec++;
      if (halted0 !== 1'b1) begin
         bad++;
         $display("FAIL rst_halt_pre: halted %b want 1", halted0);
      end
      aresetn = 1'b0;
      #1;
      vec++;
      if ({o_valid0, halted0} !== 2'b00) begin
         bad++;
         $display("FAIL rst_halt_out: vld/halt %b want 00", {o_valid0, halted0});
      end
      @(negedge clk);
      aresetn = 1'b1;
      exc = '{0};
      run0("rst_halt_after", 3);
   endtask

   task automatic test_random;
      int    n = 0;
      int    got = 0;
      int    last_c = -100;
      int    c = 0;
      bit    acc = 1'b0;
      bit    inp = 1'b0;
      beat_t e;
      do_reset;
      cfg_mode1 = GAP_MODE; cfg_gap1 = 8'd2;
      for (int p = 0; p < 30; p++) begin
         int len;
         len = $urandom_range(1, 4);
         push_pkt(len, p, 1);
         n += len;
      end
      while (got < n && c < 4000) begin
         @(negedge clk);
         if (acc) i_valid1 = 1'b0;
         acc = 1'b0;
         if (!i_valid1 && src1.size() > 0 && $urandom_range(1) == 1) begin
            i_valid1 = 1'b1;
            {i_last1, i_keep1, i_data1} = src1[0];
         end
         o_rdy1 = 1'($urandom_range(1));
         #1;
         if (i_valid1 && i_ready1) begin
            sb1.push_back(src1.pop_front());
            acc = 1'b1;
         end
         if (o_valid1 && o_rdy1) begin
            got++;
            vec++;
            if (sb1.size() == 0) begin
               bad++;
               $display("FAIL rnd_beat: unexpected output at cycle %0d", c);
            end else begin
               e = sb1.pop_front();
               if ({o_last1, o_keep1, o_data1} !== e) begin
                  bad++;
                  $display("FAIL rnd_beat: got %h want %h",
                           {o_last1, o_keep1, o_data1}, e);
               end
            end
            if (!inp) begin
               vec++;
               if (c - last_c - 1 < 2) begin
                  bad++;
                  $display("FAIL rnd_gap: %0d idle cycles want >= 2",
                           c - last_c - 1);
               end
            end
            inp = !o_last1;
            if (o_last1) last_c = c;
         end
         c++;
      end
      @(negedge clk);
      i_valid1 = 1'b0;
      @(negedge clk);
      vec++;
      if (got != n) begin
         bad++;
         $display("FAIL rnd_timeout: %0d beats out want %0d", got, n);
      end
      vec++;
      if (pkt1 !== 16'd30 || sb1.size() != 0) begin
         bad++;
         $display("FAIL rnd_cnt: pkts %0d left %0d want 30/0", pkt1, sb1.size());
      end
   endtask

   initial begin
      cfg_gap0 = '0; cfg_mode0 = 1'b0;
      cfg_gap1 = '0; cfg_mode1 = 1'b0;
      test_reset;
      test_gap3;
      test_back_to_back;
      test_period;
      test_cfg_change;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/axis_gap_shaper.md
Name: axis_gap_shaper

Overview:
- Enforces a minimum spacing between AXI-Stream packets, with the spacing set at run time rather than fixed at build time.
- Two modes:
  - GAP mode: a minimum number of idle cycles after each packet's last beat.
  - PERIOD mode: a minimum number of cycles from the start of one packet to the start of the next (rate limiting).
- An optional input register stage breaks the combinational tready path.
- Sits ahead of the MAC/PHY transmit path and ahead of rate-limited streaming sinks.

Parameters:
AXIS_BYTES, 1, data width in bytes; tdata is AXIS_BYTES*8 bits, tkeep is AXIS_BYTES bits
GAP_WIDTH, 8, width of cfg_gap and of the internal down-counter; must be >= 1
REGISTER_INPUT, 1, 1 = insert axis_skid_buffer on the input (tready registered, +1 cycle latency); 0 = combinational pass-through
PKT_CTR_WIDTH, 16, width of status_pkt_count

Ports:
clk  input  1  clock; all logic is on the rising edge
aresetn  input  1  asynchronous active-low reset; deassertion synchronised externally
cfg_gap  input  GAP_WIDTH  gap in cycles (GAP mode) or period in cycles (PERIOD mode)
cfg_mode  input  1  0 = GAP, 1 = PERIOD
axis_i_tready  output  1  input ready
axis_i_tvalid  input  1  input valid
axis_i_tlast  input  1  input last beat of packet
axis_i_tkeep  input  AXIS_BYTES  input byte enables; passed through unmodified
axis_i_tdata  input  AXIS_BYTES*8  input data
axis_o_tready  input  1  output ready
axis_o_tvalid  output  1  output valid
axis_o_tlast  output  1  output last
axis_o_tkeep  output  AXIS_BYTES  output byte enables
axis_o_tdata  output  AXIS_BYTES*8  output data
status_halted  output  1  1 while the gate is holding off a packet start
status_pkt_count  output  PKT_CTR_WIDTH  count of tlast transfers at the output; wraps to 0

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: axis_o_tvalid=0, status_halted=0, status_pkt_count=0.
  - State: state=PASS, ctr=0, in_pkt=0, skid buffer emptied.
  - axis_i_tready is 0 while aresetn=0.
- Reset mid-packet: the partial packet is discarded. The first packet after reset passes with no gap in either mode.
- Data path:
  - tdata, tlast and tkeep are never altered.
  - The gate sits after the optional skid buffer.
  - Latency: REGISTER_INPUT=0 gives 0 cycles; REGISTER_INPUT=1 gives 1 cycle.
- Gating:
  - axis_o_tvalid = buffered tvalid AND open.
  - Upstream ready into the gate = axis_o_tready AND open.
  - open is 1 whenever in_pkt=1, so beats inside a packet are never stalled by the shaper.
  - When in_pkt=0, open = (state==PASS).
- in_pkt: set on an output transfer with tlast=0; cleared on an output transfer with tlast=1.
- cfg sampling:
  - cfg_gap and cfg_mode are sampled only on the load event defined below.
  - Changing them during a gap or period does not affect the countdown in progress.
- GAP mode, load on an output tlast transfer:
  - cfg_gap==0: stay PASS; the next packet may transfer on the next cycle.
  - Otherwise: ctr<=cfg_gap and state<=HALT.
  - In HALT, ctr decrements each cycle; on ctr==1, state<=PASS.
  - Result: exactly cfg_gap cycles with axis_o_tvalid=0 after the tlast beat.
- PERIOD mode, load on an output transfer with in_pkt==0 (packet start):
  - cfg_gap<=1: no restriction.
  - Otherwise: ctr<=cfg_gap-1 and state<=HALT. The count runs concurrently with the packet. State returns to PASS when ctr reaches 0.
  - Result: consecutive packet starts are at least cfg_gap cycles apart.
  - A packet longer than the period incurs no extra gap.
  - A single-beat packet is both a start and an end; the PERIOD load applies.
- status_halted = (state==HALT) AND (in_pkt==0).
- Simultaneous events:
  - A tlast transfer while ctr is still counting (PERIOD mode) does not reload ctr.
  - A mode change takes effect at the next load event.
- Backpressure: the gap counts clock cycles, not handshakes. Downstream stalls during HALT do not extend or shorten the gap.
- The counter never wraps: the maximum gap is 2^GAP_WIDTH-1 cycles.

Decomposition:
- Package axis_pkg:
  - typedef gap_state_t {PASS, HALT}.
  - Constants GAP_MODE=1'b0 and PERIOD_MODE=1'b1.
- Sub-module axis_skid_buffer:
  - Parameter AXIS_BYTES.
  - 2-entry buffer with registered tready, full throughput.
  - Instantiated via generate only when REGISTER_INPUT=1.

Test Plan:
- GAP, cfg_gap=3, REGISTER_INPUT=0, two back-to-back 4-beat packets, tready=1 -> first packet on cycles 0-3, tvalid low on cycles 4-6, second packet starts on cycle 7; status_pkt_count=2.
- GAP, cfg_gap=0, 1-beat packets streamed continuously -> one transfer every cycle, no gaps, status_halted never 1.
- PERIOD, cfg_gap=5, 2-beat packets offered continuously -> starts at cycles 0, 5, 10; PERIOD, cfg_gap=2, 6-beat packets -> back-to-back with zero gap.
- GAP, cfg_gap=4, change cfg_gap to 1 during HALT, downstream tready=0 for 2 cycles inside the gap -> gap still exactly 4 idle cycles; the next gap uses 1.
- REGISTER_INPUT=1, random tvalid/tready at 50% -> output beat sequence equals input (tdata/tkeep/tlast scoreboard), no loss or duplication, gaps always >= cfg_gap.
- Assert aresetn=0 mid-packet (beat 2 of 4) and during HALT -> axis_o_tvalid=0 and status_halted=0 in the same cycle; after release the next packet passes with no gap.
